// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the lab3 multicycle controller.
//   state_t  : FSM state enum
//   OP_*     : IR[15:12] opcode values
//   ALU_*    : aluop encodings
//   SRC2_*   : alusrc2 encodings
//   PCSRC_*  : pcsrc encodings
//   ctrl_t   : full control word produced by ctrl_decode
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRC2_RD2 = 2'b00;
  localparam logic [1:0] SRC2_ONE = 2'b01;
  localparam logic [1:0] SRC2_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic       alusrc1;
    logic [1:0] alusrc2;
    logic [2:0] aluop;
    logic       regwrite;
    logic       memtoreg;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  // Opcodes 0xA..0xE have no defined instruction.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake.
//   mem_req   : access request (controller -> memory)
//   iord      : address select, 0 = PC, 1 = ALUOut
//   memwrite  : write qualifier, valid with mem_req
//   mem_ready : memory completes the current request this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic iord;
  logic memwrite;
  logic mem_ready;

  modport master (output mem_req, output iord, output memwrite, input mem_ready);
  modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-word decoder.
//   i_state     : current FSM state
//   i_opcode    : IR[15:12]
//   i_mem_ready : memory handshake, qualifies the fetch write enables
//   o_ctrl      : decoded control word (before reset gating)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrc2 = SRC2_ONE;
        o_ctrl.aluop   = ALU_ADD;
        o_ctrl.pcsrc   = PCSRC_ALU;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrc2 = SRC2_IMM;
        o_ctrl.aluop   = ALU_ADD;
        o_ctrl.illegal = is_illegal(i_opcode);
      end
      S_EXEC_R: begin
        o_ctrl.alusrc2 = SRC2_RD2;
        o_ctrl.aluop   = i_opcode[2:0];
      end
      S_EXEC_I: begin
        o_ctrl.alusrc2 = SRC2_IMM;
        o_ctrl.aluop   = ALU_ADD;
        // LI: 0 + imm through the zero operand
        o_ctrl.alusrc1 = (i_opcode == OP_LI);
      end
      S_ALU_WB: o_ctrl.regwrite = 1'b1;
      S_MEM_ADDR: begin
        o_ctrl.alusrc2 = SRC2_IMM;
        o_ctrl.aluop   = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrc2     = SRC2_RD2;
        o_ctrl.aluop       = ALU_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsrc       = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.pcsrc   = PCSRC_JUMP;
      end
      S_HALT:  o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multicycle control FSM for the lab3 16-bit datapath.
//   clk, reset      : clock (rising edge), async active-high reset
//   opcode          : IR[15:12]
//   zero            : ALU zero flag (consumed by the datapath via pcwritecond)
//   mem             : memory handshake (master side)
//   irwrite..halted : datapath selects/enables and status
//   instr_count     : retired-instruction counter, wraps silently
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic                 zero,
  multicycle_ctrl_if.master    mem,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 pcwritecond,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic                 alusrc1,
  output logic [1:0]           alusrc2,
  output logic [2:0]           aluop,
  output logic                 regwrite,
  output logic                 memtoreg,
  output logic                 illegal,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t              r_state;
  state_t              w_next;
  logic                r_boot;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_retire;
  ctrl_t               w_ctrl;
  logic                w_unused_zero;

  // Branch resolution happens in the datapath (pcwritecond & zero).
  assign w_unused_zero = zero;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                      (r_state == S_MEM_WR)) && !mem.mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting &&
                     (r_wait == WAIT_W'(MEM_TIMEOUT));

  assign w_retire = !r_boot &&
                    ((r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                     (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                     ((r_state == S_MEM_WR) && mem.mem_ready) ||
                     ((r_state == S_DECODE) && (opcode == OP_HALT)));

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // r_boot marks the first cycle after reset release; the FSM holds and all
  // write enables stay low so an aborted instruction cannot leave side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_boot <= 1'b1;
    else       r_boot <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!r_boot) begin
      case (r_state)
        S_FETCH:  if (mem.mem_ready) w_next = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_EXEC_R;
            OP_ADDI, OP_LI:                w_next = S_EXEC_I;
            OP_LW, OP_SW:                  w_next = S_MEM_ADDR;
            OP_BEQ:                        w_next = S_BRANCH;
            OP_J:                          w_next = S_JUMP;
            OP_HALT:                       w_next = S_HALT;
            default:                       w_next = S_FETCH;
          endcase
        end
        S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
        S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (mem.mem_ready)  w_next = S_MEM_WB;
          else if (w_timeout) w_next = S_FETCH;
        end
        S_MEM_WR: if (mem.mem_ready || w_timeout) w_next = S_FETCH;
        S_HALT:   w_next = S_HALT;
        default:  w_next = S_FETCH;
      endcase
    end
  end

  // Timeout from FETCH leaves the state unchanged, so clear on timeout as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            r_wait <= '0;
    else if ((w_next != r_state) || w_timeout || !w_waiting) r_wait <= '0;
    else if (MEM_TIMEOUT != 0)                            r_wait <= r_wait + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instr_count <= '0;
    else if (w_retire) instr_count <= instr_count + CNT_W'(1);
  end

  always_comb begin
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    pcsrc        = '0;
    alusrca      = 1'b0;
    alusrc1      = 1'b0;
    alusrc2      = '0;
    aluop        = '0;
    regwrite     = 1'b0;
    memtoreg     = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      mem.mem_req  = w_ctrl.mem_req;
      mem.iord     = w_ctrl.iord;
      mem.memwrite = w_ctrl.memwrite & ~r_boot;
      irwrite      = w_ctrl.irwrite & ~r_boot;
      pcwrite      = w_ctrl.pcwrite & ~r_boot;
      pcwritecond  = w_ctrl.pcwritecond & ~r_boot;
      pcsrc        = w_ctrl.pcsrc;
      alusrca      = w_ctrl.alusrca;
      alusrc1      = w_ctrl.alusrc1;
      alusrc2      = w_ctrl.alusrc2;
      aluop        = w_ctrl.aluop;
      regwrite     = w_ctrl.regwrite & ~r_boot;
      memtoreg     = w_ctrl.memtoreg;
      illegal      = w_ctrl.illegal | w_timeout;
      halted       = w_ctrl.halted;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        irwrite, pcwrite, pcwritecond, alusrca, alusrc1;
  logic        regwrite, memtoreg, illegal, halted;
  logic [1:0]  pcsrc, alusrc2;
  logic [2:0]  aluop;
  logic [15:0] instr_count;
  logic [15:0] exp_cnt;
  int          total = 0;
  int          bad   = 0;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.CNT_W(16), .MEM_TIMEOUT(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem(mem_if),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrc1(alusrc1), .alusrc2(alusrc2),
    .aluop(aluop), .regwrite(regwrite), .memtoreg(memtoreg),
    .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {mem_req,iord,memwrite,irwrite,pcwrite,pcwritecond,pcsrc,alusrca,alusrc1,
  //  alusrc2,aluop,regwrite,memtoreg,illegal,halted}
  localparam logic [18:0] V_ZERO       = 19'b0_0_0_0_0_0_00_0_0_00_000_0_0_0_0;
  localparam logic [18:0] V_FETCH_WAIT = 19'b1_0_0_0_0_0_00_1_0_01_000_0_0_0_0;
  localparam logic [18:0] V_FETCH_GO   = 19'b1_0_0_1_1_0_00_1_0_01_000_0_0_0_0;
  localparam logic [18:0] V_DECODE     = 19'b0_0_0_0_0_0_00_1_0_10_000_0_0_0_0;
  localparam logic [18:0] V_DECODE_ILL = 19'b0_0_0_0_0_0_00_1_0_10_000_0_0_1_0;
  localparam logic [18:0] V_EXEC_ADD   = 19'b0_0_0_0_0_0_00_0_0_00_000_0_0_0_0;
  localparam logic [18:0] V_EXEC_OR    = 19'b0_0_0_0_0_0_00_0_0_00_011_0_0_0_0;
  localparam logic [18:0] V_EXEC_LI    = 19'b0_0_0_0_0_0_00_0_1_10_000_0_0_0_0;
  localparam logic [18:0] V_ALU_WB     = 19'b0_0_0_0_0_0_00_0_0_00_000_1_0_0_0;
  localparam logic [18:0] V_MEM_ADDR   = 19'b0_0_0_0_0_0_00_0_0_10_000_0_0_0_0;
  localparam logic [18:0] V_MEM_RD     = 19'b1_1_0_0_0_0_00_0_0_00_000_0_0_0_0;
  localparam logic [18:0] V_MEM_WB     = 19'b0_0_0_0_0_0_00_0_0_00_000_1_1_0_0;
  localparam logic [18:0] V_MEM_WR     = 19'b1_1_1_0_0_0_00_0_0_00_000_0_0_0_0;
  localparam logic [18:0] V_BRANCH     = 19'b0_0_0_0_0_1_01_0_0_00_001_0_0_0_0;
  localparam logic [18:0] V_JUMP       = 19'b0_0_0_0_1_0_10_0_0_00_000_0_0_0_0;
  localparam logic [18:0] V_HALT       = 19'b0_0_0_0_0_0_00_0_0_00_000_0_0_0_1;

  function automatic logic [18:0] outs();
    return {mem_if.mem_req, mem_if.iord, mem_if.memwrite, irwrite, pcwrite,
            pcwritecond, pcsrc, alusrca, alusrc1, alusrc2, aluop, regwrite,
            memtoreg, illegal, halted};
  endfunction

  // Every task starts just after a falling edge, at the first cycle of a FETCH.
  task automatic test_reset();
    reset = 1'b1; mem_if.mem_ready = 1'b1; opcode = 4'h0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; total++;
      if (outs() !== V_ZERO || instr_count !== 16'd0) begin
        bad++; $display("FAIL reset_hold cyc%0d: outs=%b cnt=%0d want %b cnt=0",
                        i, outs(), instr_count, V_ZERO);
      end
      @(negedge clk);
    end
    reset = 1'b0; #1; total++;
    if (outs() !== V_FETCH_WAIT) begin
      bad++; $display("FAIL reset_release: outs=%b want %b", outs(), V_FETCH_WAIT);
    end
    @(negedge clk);
    exp_cnt = 16'd0;
  endtask

  task automatic test_add();
    logic [18:0] ev [4];
    ev = '{V_FETCH_GO, V_DECODE, V_EXEC_ADD, V_ALU_WB};
    opcode = 4'h0; mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL add cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL add_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_or_fetch_wait();
    logic [18:0] ev [5];
    logic        rq [5];
    ev = '{V_FETCH_WAIT, V_FETCH_GO, V_DECODE, V_EXEC_OR, V_ALU_WB};
    rq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 4'h3;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_ready = rq[i]; #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL or_wait cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL or_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_li();
    logic [18:0] ev [4];
    ev = '{V_FETCH_GO, V_DECODE, V_EXEC_LI, V_ALU_WB};
    opcode = 4'h5; mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL li cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL li_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] ev [8];
    logic        rq [8];
    ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD,
           V_MEM_RD, V_MEM_WB};
    rq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 4'h6;
    for (int i = 0; i < 8; i++) begin
      mem_if.mem_ready = rq[i]; #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL lw cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL lw_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw_wait();
    logic [18:0] ev [5];
    logic        rq [5];
    ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_WR, V_MEM_WR};
    rq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 4'h7;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_ready = rq[i]; #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL sw cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL sw_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq();
    logic [18:0] ev [3];
    ev = '{V_FETCH_GO, V_DECODE, V_BRANCH};
    opcode = 4'h8; mem_if.mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 3; i++) begin
        #1; total++;
        if (outs() !== ev[i]) begin
          bad++; $display("FAIL beq_z%0d cyc%0d: outs=%b want %b", z, i + 1, outs(), ev[i]);
        end
        @(negedge clk);
      end
      exp_cnt = exp_cnt + 16'd1; #1; total++;
      if (instr_count !== exp_cnt) begin
        bad++; $display("FAIL beq_z%0d_count: got %0d want %0d", z, instr_count, exp_cnt);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [18:0] ev [3];
    ev = '{V_FETCH_GO, V_DECODE, V_JUMP};
    opcode = 4'h9; mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL jump cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL jump_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [18:0] ev [4];
    logic        rq [4];
    ev = '{V_FETCH_GO, V_DECODE, V_MEM_ADDR, V_MEM_RD};
    rq = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 4'h6;
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_ready = rq[i]; #1; total++;
      if (outs() !== ev[i]) begin
        bad++; $display("FAIL rst_lw cyc%0d: outs=%b want %b", i + 1, outs(), ev[i]);
      end
      @(negedge clk);
    end
    // Still in MEM_RD: reset for three cycles with memory ready throughout.
    reset = 1'b1; mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (outs() !== V_ZERO || instr_count !== 16'd0) begin
        bad++; $display("FAIL rst_mid cyc%0d: outs=%b cnt=%0d want %b cnt=0",
                        i, outs(), instr_count, V_ZERO);
      end
      @(negedge clk);
    end
    reset = 1'b0; #1; total++;
    if (outs() !== V_FETCH_WAIT) begin
      bad++; $display("FAIL rst_mid_release: outs=%b want %b", outs(), V_FETCH_WAIT);
    end
    @(negedge clk);
    exp_cnt = 16'd0; #1; total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL rst_mid_count: got %0d want 0", instr_count);
    end
  endtask

  task automatic test_illegal_halt();
    opcode = 4'hC; mem_if.mem_ready = 1'b1;
    #1; total++;
    if (outs() !== V_FETCH_GO) begin
      bad++; $display("FAIL ill_fetch: outs=%b want %b", outs(), V_FETCH_GO);
    end
    @(negedge clk); #1; total++;
    if (outs() !== V_DECODE_ILL) begin
      bad++; $display("FAIL ill_decode: outs=%b want %b", outs(), V_DECODE_ILL);
    end
    @(negedge clk);
    opcode = 4'hF; #1; total++;
    if (outs() !== V_FETCH_GO || instr_count !== exp_cnt) begin
      bad++; $display("FAIL ill_back: outs=%b cnt=%0d want %b cnt=%0d",
                      outs(), instr_count, V_FETCH_GO, exp_cnt);
    end
    @(negedge clk); #1; total++;
    if (outs() !== V_DECODE) begin
      bad++; $display("FAIL halt_decode: outs=%b want %b", outs(), V_DECODE);
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    for (int i = 0; i < 20; i++) begin
      mem_if.mem_ready = i[0]; #1; total++;
      if (outs() !== V_HALT || instr_count !== exp_cnt) begin
        bad++; $display("FAIL halt cyc%0d: outs=%b cnt=%0d want %b cnt=%0d",
                        i, outs(), instr_count, V_HALT, exp_cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_or_fetch_wait();
    test_li();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_jump();
    test_reset_mid_lw();
    test_illegal_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style multicycle control FSM for the lab3 16-bit datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable, including the zero-operand select `alusrc1` that forces ALU operand A to 0.
- Handshakes with a shared instruction/data memory and keeps a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter `instr_count`.
- MEM_TIMEOUT, 0, wait-cycle limit on `mem_ready`; 0 = wait forever.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  4  IR[15:12] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- memwrite  out  1  write qualifier, valid with mem_req.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load if zero.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  operand A pre-select: 0 = rd1, 1 = PC.
- alusrc1  out  1  1 = force operand A to 0 (after alusrca).
- alusrc2  out  2  00 = rd2, 01 = const 1, 10 = sign-extended imm.
- aluop  out  3  000 add, 001 sub, 010 and, 011 or.
- regwrite  out  1  register file write.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  FSM in HALT.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LI, 6 LW, 7 SW, 8 BEQ, 9 J, F HALT; 10-14 illegal.
- Reset:
  - state = FETCH, instr_count = 0.
  - While reset is high, all outputs are 0.
  - Reset mid-instruction aborts it: no write enable asserts in the reset cycle or the first cycle after release.
- Outputs are decoded from state only, except the write enables qualified by mem_ready as listed below. Unlisted outputs are 0.
- FETCH:
  - Asserts mem_req, iord=0, alusrca=1, alusrc2=01, aluop=add, pcsrc=00.
  - irwrite and pcwrite are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE.
  - Otherwise it holds in FETCH.
- DECODE:
  - ALUOut <= PC + imm: alusrca=1, alusrc2=10, add.
  - Next state by opcode:
    - 0-3 -> EXEC_R.
    - 4, 5 -> EXEC_I.
    - 6, 7 -> MEM_ADDR.
    - 8 -> BRANCH.
    - 9 -> JUMP.
    - F -> HALT.
    - Illegal -> FETCH with illegal=1 for one cycle; not counted as retired.
- EXEC_R: alusrca=0, alusrc1=0, alusrc2=00, aluop = opcode[2:0] -> ALU_WB.
- EXEC_I: alusrc2=10, add, alusrc1 = (opcode==5) -> ALU_WB.
  - LI writes imm via the zero operand.
- ALU_WB: regwrite=1, memtoreg=0 -> FETCH.
- MEM_ADDR: alusrc2=10, add -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, iord=1; holds until mem_ready -> MEM_WB.
- MEM_WB: regwrite=1, memtoreg=1 -> FETCH.
- MEM_WR: mem_req=1, iord=1, memwrite=1; -> FETCH when mem_ready.
- BRANCH: alusrc2=00, sub, pcwritecond=1, pcsrc=01 -> FETCH.
- JUMP: pcwrite=1, pcsrc=10 -> FETCH.
- HALT: halted=1, no requests, no enables; exits only on reset.
- Cycle counts with zero-wait memory:
  - R/I: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/J: 3.
- instr_count:
  - +1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP.
  - Also +1 once on entry to HALT.
  - Wraps modulo 2^CNT_W without flag.
- Timeout (MEM_TIMEOUT>0):
  - Applies after MEM_TIMEOUT consecutive waiting cycles in FETCH/MEM_RD/MEM_WR.
  - Pulses illegal, drops the access with no writes, and returns to FETCH.
  - The wait counter clears on every state change.
- mem_req stays high and iord stays stable while waiting; no request asserts outside FETCH/MEM_RD/MEM_WR.

Decomposition:
- Package `ctrl_pkg` holds:
  - `state_t` enum.
  - Opcode localparams.
  - aluop, alusrc2 and pcsrc encodings.
- Sub-module `ctrl_decode`: combinational state -> control-word decoder, instantiated once.
- The FSM register, wait counter and instr_count live in the top.

Test Plan:
- Reset: hold reset 3 cycles mid-MEM_RD of an LW -> all outputs 0, no regwrite after release, next state FETCH, instr_count=0.
- ADD, opcode 0, mem_ready tied 1:
  - Cycle 1: irwrite/pcwrite.
  - Cycle 3: aluop=000, alusrc1=0.
  - Cycle 4: regwrite=1.
  - instr_count=1 after 4 cycles.
- LI, opcode 5, imm 0x07 -> EXEC_I shows alusrc1=1, alusrc2=10, aluop=000; regwrite=1 with memtoreg=0 one cycle later.
- LW with mem_ready delayed 3 cycles in MEM_RD:
  - mem_req and iord=1 held 4 cycles.
  - Then MEM_WB with regwrite=1, memtoreg=1.
  - Total 8 cycles.
- BEQ with zero=1 and then zero=0 -> pcwritecond=1, pcsrc=01, aluop=001 in both; 3 cycles each.
- Opcode 0xC, then HALT (0xF):
  - 0xC: illegal pulses once, instr_count unchanged.
  - 0xF: halted=1, mem_req stays 0 for 20 cycles, instr_count +1.
